// File: rtl/uart_rx.sv
`default_nettype none
// uart_rx -- UART receiver: 2-FF synchronized line, mid-bit sampling, LSB-first data, stop-bit error flag.
// Revision 1.0
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FRAME_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [FRAME_BITS-3:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_err
);

  localparam int DW   = FRAME_BITS - 2;
  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW   = $clog2(DW + 1);

  localparam logic [CW-1:0] C_HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_CPB_M1   = CW'(CPB - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic            rx_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == C_HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == C_CPB_M1) begin
          cnt_d = '0;
          // Right shift: the first bit received ends up in bit 0.
          shift_d         = shift_q >> 1;
          shift_d[DW-1]   = rx_s;
          bit_d           = bit_q + BW'(1);
          if (bit_q == C_LAST_BIT) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == C_CPB_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // A held-low line must return high before a new start is accepted.
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire
